// File: rtl/riscv_fetch_fifo_gen.sv
// riscv_fetch_fifo_gen: instruction prefetch FIFO of 32-bit fetch words with
// 16/32-bit RVC realignment, including 32-bit instructions straddling two words.
module riscv_fetch_fifo_gen #(
  parameter int DEPTH       = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic [ADDR_WIDTH-1:0]        in_addr_i,
  input  logic [31:0]                  in_rdata_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_rdata_o,
  output logic [ADDR_WIDTH-1:0]        out_addr_o,
  output logic                         out_is_compressed_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         almost_full_o,
  output logic                         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_d [DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  half_q, half_d, first_q, first_d;
  logic [31:0]           head, nxt;
  logic [15:0]           hw;
  logic                  comp, push, fire, pop;
  always_comb begin
    head = mem_q[rd_ptr_q];
    nxt = mem_q[rd_ptr_q + PW'(1)];
    hw = half_q ? head[31:16] : head[15:0];
    comp = hw[1:0] != 2'b11;
    in_ready_o = 32'(count_q) < DEPTH;
    // an upper-half 32-bit instruction needs the following word as well
    out_valid_o = (half_q && !comp) ? count_q >= CW'(2) : count_q != '0;
    out_rdata_o = comp ? {16'h0, hw} : half_q ? {nxt[15:0], hw} : head;
    out_addr_o = {addr_q[rd_ptr_q][ADDR_WIDTH-1:2], half_q, 1'b0};
    out_is_compressed_o = comp;
    count_o = count_q;
    empty_o = count_q == '0;
    almost_full_o = 32'(count_q) >= AFULL_LEVEL;
    push = in_valid_i && in_ready_o;
    fire = out_valid_o && out_ready_i;
    pop = fire && (half_q || !comp);
    mem_d = mem_q;
    addr_d = addr_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_rdata_i;
      addr_d[wr_ptr_q] = {in_addr_i[ADDR_WIDTH-1:2], 2'b00};
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d = count_q + CW'(push) - CW'(pop);
    half_d = (first_q && push) ? in_addr_i[1] : (fire && comp) ? !half_q : half_q;
    first_d = first_q && !push;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d = '0;
      half_d = 1'b0;
      first_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
        addr_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
      half_q <= 1'b0;
      first_q <= 1'b1;
    end else begin
      mem_q <= mem_d;
      addr_q <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
      half_q <= half_d;
      first_q <= first_d;
    end
  end
endmodule

// File: tb/tb_riscv_fetch_fifo_gen.sv
// tb_riscv_fetch_fifo_gen: scoreboard bench; a halfword-stream model assembles
// expected instructions on push, a negedge monitor compares on each handshake.
module tb_riscv_fetch_fifo_gen;
  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int AF = DEPTH - 1;
  logic clk = 1'b0, rst = 1'b1, clear_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [AW-1:0] in_addr_i = '0;
  logic [31:0] in_rdata_i = '0;
  logic in_ready_o, out_valid_o, out_is_compressed_o, almost_full_o, empty_o;
  logic [31:0] out_rdata_o;
  logic [AW-1:0] out_addr_o;
  logic [$clog2(DEPTH+1)-1:0] count_o;
  riscv_fetch_fifo_gen #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .AFULL_LEVEL(AF)) dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .in_addr_i(in_addr_i),
    .in_rdata_i(in_rdata_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_rdata_o(out_rdata_o),
    .out_addr_o(out_addr_o), .out_is_compressed_o(out_is_compressed_o),
    .count_o(count_o), .almost_full_o(almost_full_o), .empty_o(empty_o));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] d; logic [AW-1:0] a; bit c; int pops;} ins_t;
  typedef struct {logic [15:0] h; logic [AW-1:0] a; bit up;} hw_t;
  ins_t exp_q[$];
  hw_t hq[$];
  int mcount = 0;
  bit mfirst = 1'b1;
  int total = 0, bad = 0;
  logic [AW-1:0] nxt_addr = '0;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, req, $time);
    end
  endfunction
  function automatic void model_reset();
    exp_q.delete();
    hq.delete();
    mcount = 0;
    mfirst = 1'b1;
  endfunction
  // a word becomes two halfwords (only the upper one if the stream starts mid-word)
  function automatic void model_push(logic [31:0] w, logic [AW-1:0] a);
    if (!(mfirst && a[1])) hq.push_back('{w[15:0], {a[AW-1:2], 2'b00}, 1'b0});
    hq.push_back('{w[31:16], {a[AW-1:2], 2'b10}, 1'b1});
    mfirst = 1'b0;
    mcount++;
    while (hq.size() > 0) begin
      if (hq[0].h[1:0] != 2'b11) begin
        exp_q.push_back('{{16'h0, hq[0].h}, hq[0].a, 1'b1, hq[0].up ? 1 : 0});
        void'(hq.pop_front());
      end else if (hq.size() >= 2) begin
        exp_q.push_back('{{hq[1].h, hq[0].h}, hq[0].a, 1'b0, (hq[0].up ? 1 : 0) + (hq[1].up ? 1 : 0)});
        void'(hq.pop_front());
        void'(hq.pop_front());
      end else break;
    end
  endfunction
  always @(negedge clk) begin
    ins_t e;
    chk("count", 32'(count_o), 32'(mcount));
    chk("empty", 32'(empty_o), 32'(mcount == 0));
    chk("in_ready", 32'(in_ready_o), 32'(mcount < DEPTH));
    chk("almost_full", 32'(almost_full_o), 32'(mcount >= AF));
    chk("out_valid", 32'(out_valid_o), 32'(exp_q.size() > 0));
    if (!rst && !clear_i && out_valid_o && out_ready_i && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rdata", out_rdata_o, e.d);
      chk("addr", out_addr_o, e.a);
      chk("is_compressed", 32'(out_is_compressed_o), 32'(e.c));
      mcount -= e.pops;
    end
  end
  task automatic step(bit v, logic [31:0] d, bit r, bit c);
    bit p;
    in_valid_i = v;
    in_rdata_i = d;
    in_addr_i = nxt_addr;
    out_ready_i = r;
    clear_i = c;
    p = v && mcount < DEPTH && !c;
    @(posedge clk);
    #1;
    if (c) model_reset();
    else if (p) begin
      model_push(d, nxt_addr);
      nxt_addr = {nxt_addr[AW-1:2], 2'b00} + AW'(4);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid_i = 1'b0;
    out_ready_i = 1'b0;
    clear_i = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic drain(int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask
  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 1) h[1:0] = 2'b11;
    else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
    return h;
  endfunction
  initial begin
    logic [31:0] t;
    #12 rst = 1'b0;
    @(posedge clk);
    #1;
    nxt_addr = 32'h100;
    step(1'b1, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'h00000093, 1'b0, 1'b0);
    drain(3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    nxt_addr = 32'h200;
    step(1'b1, 32'h45014501, 1'b1, 1'b0);
    drain(3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    nxt_addr = 32'h300;
    step(1'b1, 32'h00134501, 1'b1, 1'b0);
    drain(3);
    step(1'b1, 32'h00930000, 1'b1, 1'b0);
    drain(3);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    nxt_addr = 32'h0;
    for (int i = 0; i < 5; i++) step(1'b1, 32'h00000013, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h00000013, 1'b0, 1'b0);
    drain(6);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    nxt_addr = 32'h402;
    step(1'b1, 32'h4505abcd, 1'b1, 1'b0);
    drain(2);
    step(1'b1, 32'h00000013, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 1'b0, 1'b1);
    drain(2);
    nxt_addr = 32'h600;
    for (int i = 0; i < 3; i++) step(1'b1, 32'h00000013, 1'b0, 1'b0);
    do_reset();
    nxt_addr = 32'h502;
    step(1'b1, 32'h00014501, 1'b1, 1'b0);
    drain(3);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(299) == 0) begin
        do_reset();
        t = $urandom;
        nxt_addr = {t[AW-1:2], 2'b00} | {30'h0, t[1], 1'b0};
      end else if ($urandom_range(99) == 0) begin
        step(1'b1, {rand_half(), rand_half()}, 1'($urandom_range(1)), 1'b1);
        t = $urandom;
        nxt_addr = {t[AW-1:2], 2'b00} | {30'h0, t[1], 1'b0};
      end else begin
        step(1'($urandom_range(2) != 0), {rand_half(), rand_half()},
             1'($urandom_range(3) != 0), 1'b0);
      end
    end
    drain(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
